// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the ADC decimator slice.
//   ADC_DECIM_LOG2_DEF - default log2 of the decimation ratio
//   adc_out_w()        - sample width that holds the full-scale count
//   adc_decim_state_t  - window FSM states
package adc_pkg;

  localparam int ADC_DECIM_LOG2_DEF = 6;

  // A window of 2^n ones counts to 2^n, which needs n+1 bits.
  function automatic int adc_out_w(input int decim_log2);
    return decim_log2 + 1;
  endfunction

  typedef enum logic {IDLE, ACCUM} adc_decim_state_t;

endpackage

// File: rtl/adc_bit_sync.sv
// adc_bit_sync: 2-flop synchronizer for the comparator bitstream.
//   clk   in  system clock
//   reset in  asynchronous active-low reset (flops clear to 0)
//   d     in  asynchronous input bit
//   q     out synchronized bit, 2 clocks behind d
module adc_bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;

  always_comb begin
    ff1_d = d;
    ff2_d = ff1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/adc_decimator.sv
// adc_decimator: counts ones in the 1-bit comparator stream over windows of
// 2^DECIM_LOG2 clocks and emits one count per window through a single-entry
// valid/ready output register. A finished count that finds the register
// occupied (and not being popped) is dropped and raises a sticky overrun.
//   clk          in  system clock
//   reset        in  asynchronous active-low reset
//   enable       in  1 = accumulate windows, 0 = idle (partial discarded)
//   bit_in       in  comparator bitstream
//   sample_data  out count of ones in the last completed window
//   sample_valid out sample_data holds an unconsumed sample
//   sample_ready in  consumer accepts the sample
//   overrun      out sticky: a completed sample was dropped
//   overrun_clr  in  synchronous clear of overrun (a new overrun wins)
// Build option ADC_DECIM_SYNC_EN: bit_in goes through a 2-flop synchronizer;
// enable is delayed by the same 2 clocks so the window still covers the raw
// bits from the enable-rise clock onward.
module adc_decimator
  import adc_pkg::*;
#(
  parameter int DECIM_LOG2 = ADC_DECIM_LOG2_DEF,
  parameter int OUT_W      = adc_out_w(DECIM_LOG2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bit_in,
  output logic [OUT_W-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam logic [DECIM_LOG2-1:0] PH_MAX = '1;

  logic bit_s, en_s;

`ifdef ADC_DECIM_SYNC_EN
  logic [1:0] en_pipe_q, en_pipe_d;

  adc_bit_sync u_sync (.clk(clk), .reset(reset), .d(bit_in), .q(bit_s));

  always_comb en_pipe_d = {en_pipe_q[0], enable};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) en_pipe_q <= '0;
    else        en_pipe_q <= en_pipe_d;
  end

  assign en_s = en_pipe_q[1];
`else
  assign bit_s = bit_in;
  assign en_s  = enable;
`endif

  adc_decim_state_t      state_q, state_d;
  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic [OUT_W-1:0]      acc_q, acc_d;
  // One-stage hand-off of a finished window to the output register.
  logic                  done_q, done_d;
  logic [OUT_W-1:0]      result_q, result_d;
  logic [OUT_W-1:0]      data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic [DECIM_LOG2-1:0] phase_cur;
  logic [OUT_W-1:0]      acc_sum;

  // Window counters: the enable-rise clock already counts as bit 0.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    result_d  = result_q;
    phase_cur = (state_q == ACCUM) ? phase_q : '0;
    acc_sum   = ((state_q == ACCUM) ? acc_q : '0) + OUT_W'(bit_s);
    if (!en_s) begin
      state_d = IDLE;
      phase_d = '0;
      acc_d   = '0;
    end else begin
      state_d = ACCUM;
      if (phase_cur == PH_MAX) begin
        done_d   = 1'b1;
        result_d = acc_sum;
        phase_d  = '0;
        acc_d    = '0;
      end else begin
        phase_d = phase_cur + 1'b1;
        acc_d   = acc_sum;
      end
    end
  end

  // Output register: a pop in the completion cycle frees the slot.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (overrun_clr) ovr_d = 1'b0;
    if (done_q) begin
      if (!valid_q || sample_ready) begin
        data_d  = result_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      result_q <= result_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_decimator.sv
// tb_adc_decimator: directed checks of adc_decimator with DECIM_LOG2 = 3
// (8-clock windows, 4-bit samples). Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point.
module tb_adc_decimator;

  localparam int L = 3;
  localparam int W = L + 1;
`ifdef ADC_DECIM_SYNC_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 9;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         bit_in = 1'b0;
  logic [W-1:0] sample_data;
  logic         sample_valid;
  logic         sample_ready = 1'b0;
  logic         overrun;
  logic         overrun_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  adc_decimator #(.DECIM_LOG2(L)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bit_in(bit_in),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    enable = 0; bit_in = 0; sample_ready = 0; overrun_clr = 0;
    reset = 0;
    tick();
    reset = 1;
    tick();
  endtask

  task automatic test_reset();
    enable = 0; bit_in = 0; sample_ready = 0; overrun_clr = 0;
    reset = 0;
    tick(); tick();
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    n_cmp++; if (sample_data !== 4'd0) begin n_bad++; $display("FAIL reset_data got %0d want 0", sample_data); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
    reset = 1;
    tick();
  endtask

  task automatic test_all_ones();
    logic exp;
    apply_reset();
    enable = 1; bit_in = 1; sample_ready = 1;
    for (int t = 1; t <= LAT + 16; t++) begin
      tick();
      exp = (t >= LAT) && ((t - LAT) % 8 == 0);
      n_cmp++; if (sample_valid !== exp) begin n_bad++; $display("FAIL ones_valid t=%0d got %b want %b", t, sample_valid, exp); end
      if (exp) begin
        n_cmp++; if (sample_data !== 4'd8) begin n_bad++; $display("FAIL ones_data t=%0d got %0d want 8", t, sample_data); end
      end
    end
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    logic       exp;
    pat = 8'b1000_1101;  // bit k of the window = pat[k]: 1,0,1,1,0,0,0,1
    apply_reset();
    enable = 1; sample_ready = 1;
    for (int t = 1; t <= LAT + 16; t++) begin
      bit_in = pat[(t - 1) % 8];
      tick();
      exp = (t >= LAT) && ((t - LAT) % 8 == 0);
      n_cmp++; if (sample_valid !== exp) begin n_bad++; $display("FAIL pat_valid t=%0d got %b want %b", t, sample_valid, exp); end
      if (exp) begin
        n_cmp++; if (sample_data !== 4'd4) begin n_bad++; $display("FAIL pat_data t=%0d got %0d want 4", t, sample_data); end
      end
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    enable = 1; sample_ready = 0;
    for (int t = 1; t <= LAT + 16; t++) begin
      bit_in      = (t > 8);                       // window 2 counts 8
      overrun_clr = (t == LAT + 9) || (t == LAT + 16);
      tick();
      if (t == LAT) begin
        n_cmp++; if (sample_valid !== 1'b1 || sample_data !== 4'd0) begin n_bad++; $display("FAIL ovr_first got v=%b d=%0d want v=1 d=0", sample_valid, sample_data); end
      end
      if (t == LAT + 7) begin
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_early got %b want 0", overrun); end
      end
      if (t == LAT + 8) begin
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", overrun); end
        n_cmp++; if (sample_valid !== 1'b1 || sample_data !== 4'd0) begin n_bad++; $display("FAIL ovr_hold got v=%b d=%0d want v=1 d=0", sample_valid, sample_data); end
      end
      if (t == LAT + 9) begin
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr got %b want 0", overrun); end
      end
      if (t == LAT + 16) begin
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
      end
    end
    overrun_clr = 0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    enable = 1;
    for (int t = 1; t <= LAT + 9; t++) begin
      bit_in       = (t <= 8);                     // window 1 = 8, window 2 = 0
      sample_ready = (t == LAT + 8) || (t == LAT + 9);
      tick();
      if (t == LAT) begin
        n_cmp++; if (sample_valid !== 1'b1 || sample_data !== 4'd8) begin n_bad++; $display("FAIL b2b_first got v=%b d=%0d want v=1 d=8", sample_valid, sample_data); end
      end
      if (t == LAT + 8) begin
        n_cmp++; if (sample_valid !== 1'b1 || sample_data !== 4'd0) begin n_bad++; $display("FAIL b2b_load got v=%b d=%0d want v=1 d=0", sample_valid, sample_data); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %b want 0", overrun); end
      end
      if (t == LAT + 9) begin
        n_cmp++; if (sample_valid !== 1'b0 || sample_data !== 4'd0) begin n_bad++; $display("FAIL b2b_pop got v=%b d=%0d want v=0 d=0 held", sample_valid, sample_data); end
      end
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    enable = 1; bit_in = 1; sample_ready = 1;
    for (int t = 1; t <= 8 + LAT; t++) begin
      enable = !(t >= 6 && t <= 8);                // 5 bits, then 3 idle clocks
      tick();
      if (t < 8 + LAT) begin
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL drop_spurious t=%0d got %b want 0", t, sample_valid); end
      end else begin
        n_cmp++; if (sample_valid !== 1'b1 || sample_data !== 4'd8) begin n_bad++; $display("FAIL drop_sample got v=%b d=%0d want v=1 d=8", sample_valid, sample_data); end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    enable = 1; bit_in = 1; sample_ready = 0;
    for (int t = 1; t <= LAT + 11; t++) tick();
    n_cmp++; if (sample_valid !== 1'b1 || overrun !== 1'b1 || sample_data !== 4'd8) begin n_bad++; $display("FAIL mid_pre got v=%b o=%b d=%0d want 1 1 8", sample_valid, overrun, sample_data); end
    #2 reset = 0;
    #1;
    n_cmp++; if (sample_valid !== 1'b0 || overrun !== 1'b0 || sample_data !== 4'd0) begin n_bad++; $display("FAIL mid_async got v=%b o=%b d=%0d want 0 0 0", sample_valid, overrun, sample_data); end
    enable = 0;
    tick();
    reset = 1;
    for (int t = 0; t < 12; t++) tick();
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_emit got %b want 0", sample_valid); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_pattern();
    test_overrun();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_decimator.md
Name: adc_decimator

Overview:
- Downstream consumer of the 1-bit comparator output of the adc stage; sigma-delta-style decimator.
- Counts '1' bits over a fixed window of 2^DECIM_LOG2 clocks and emits one multi-bit sample per window.
- Output goes through a single-entry valid/ready register toward the sample FIFO/processing logic.
- Overrun is flagged and sticky when a finished sample cannot be stored.

Parameters:
- DECIM_LOG2, 6, log2 of decimation ratio (window = 64 clocks); legal range 1..12.
- OUT_W, DECIM_LOG2+1, sample width; holds the full-scale count 2^DECIM_LOG2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; assertion clears all state immediately.
- enable  in  1  1 = accumulate windows; 0 = idle, partial window discarded.
- bit_in  in  1  bitstream from adc digital_out.
- sample_data  out  OUT_W  count of ones in the last completed window.
- sample_valid  out  1  sample_data holds an unconsumed sample.
- sample_ready  in  1  consumer accepts; transfer occurs when valid && ready on a clk edge.
- overrun  out  1  sticky; a completed sample was dropped.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset values:
  - sample_data = 0, sample_valid = 0, overrun = 0.
  - phase counter = 0, accumulator = 0, state = IDLE.
- States:
  - IDLE: counters held at 0. Goes to ACCUM on the first clk with enable = 1; that cycle's bit_in is bit 0 of the window.
  - ACCUM: each cycle, acc += bit_in and phase += 1. On phase == 2^DECIM_LOG2-1, the window completes: result = acc + bit_in, then acc and phase restart at 0 with the next window beginning the following cycle (no gap). enable = 0 goes to IDLE and discards the partial window.
- Latency: sample_valid rises the clk after the last bit of the window; the first sample appears 2^DECIM_LOG2 + 1 clocks after enable rises.
- Width: the accumulator is OUT_W bits. All-ones gives 2^DECIM_LOG2; all-zeros gives 0. No saturation is needed.
- Output register, on window completion:
  - If !sample_valid, or sample_ready is high that cycle: load result, sample_valid = 1.
  - Otherwise: keep the old sample, drop result, set overrun = 1.
- Without completion: valid && ready clears sample_valid; sample_data is held (not zeroed).
- Simultaneous pop and completion: the old sample transfers, the new one loads, valid stays 1, no overrun.
- overrun_clr and a new overrun in the same cycle: overrun = 1 (set wins).
- Dropping enable does not affect a pending sample_valid or overrun.
- Reset mid-window or with valid pending: everything returns to reset values; no sample is emitted.
- sample_data/sample_valid are stable while valid && !ready.

Optional Feature:
- Macro ADC_DECIM_SYNC_EN.
- Defined: bit_in passes through a 2-flop synchronizer (reset value 0) before accumulation. All bit-to-sample latencies grow by 2 clocks. The window still starts on the enable-rise clk and counts the synchronized bits.
- Undefined: bit_in is used directly; the caller guarantees it is synchronous to clk.

Decomposition:
- Package adc_pkg:
  - ADC_DECIM_LOG2_DEF = 6.
  - Function for OUT_W.
  - State enum adc_decim_state_t {IDLE, ACCUM}.
- Sub-module adc_bit_sync (2-flop synchronizer), instantiated only under ADC_DECIM_SYNC_EN.
- Counters and output register stay in adc_decimator.

Test Plan:
- DECIM_LOG2=3, reset released, enable=1, bit_in=1 constant, ready=1 -> sample_valid pulses every 8 clocks, sample_data=8; first valid 9 clocks after enable.
- bit_in pattern 1,0,1,1,0,0,0,1 repeated, ready=1 -> each sample_data=4.
- ready=0 for 20 clocks, bit_in=0 -> first sample 0 held with valid=1; second completion sets overrun=1 while data stays 0. overrun_clr -> overrun=0 next clk.
- ready asserted exactly on the completion cycle with valid pending -> no overrun, new sample loaded, valid stays 1.
- enable dropped at phase 5 with bit_in=1, re-raised -> next sample=8 (partial discarded), no spurious valid.
- reset asserted mid-window with valid=1 -> sample_valid, sample_data and overrun go 0 asynchronously. Build with ADC_DECIM_SYNC_EN -> first valid at 11 clocks after enable.
